// File: rtl/acc_req_arbiter_if.sv
// Requester-side and accelerator-side handshake bundle for acc_req_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface acc_req_arbiter_if #(
    parameter int NrReq = 2,
    parameter int IdW   = 3,
    parameter int DataW = 64
);
    localparam int SrcW = $clog2(NrReq);

    logic [NrReq-1:0]             req_valid_i;
    logic [NrReq-1:0]             req_ready_o;
    logic [NrReq-1:0][31:0]       req_insn_i;
    logic [NrReq-1:0][DataW-1:0]  req_rs1_i;
    logic [NrReq-1:0][DataW-1:0]  req_rs2_i;
    logic [NrReq-1:0][IdW-1:0]    req_id_i;

    logic [NrReq-1:0]             resp_valid_o;
    logic [IdW-1:0]               resp_id_o;
    logic [DataW-1:0]             resp_result_o;
    logic                         resp_error_o;

    logic                         acc_req_valid_o;
    logic                         acc_req_ready_i;
    logic [31:0]                  acc_insn_o;
    logic [DataW-1:0]             acc_rs1_o;
    logic [DataW-1:0]             acc_rs2_o;
    logic [SrcW+IdW-1:0]          acc_id_o;

    logic                         acc_resp_valid_i;
    logic [SrcW+IdW-1:0]          acc_resp_id_i;
    logic [DataW-1:0]             acc_resp_result_i;
    logic                         acc_resp_error_i;

    modport slave (
        input  req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_id_i,
        output req_ready_o,
        output resp_valid_o, resp_id_o, resp_result_o, resp_error_o,
        output acc_req_valid_o, acc_insn_o, acc_rs1_o, acc_rs2_o, acc_id_o,
        input  acc_req_ready_i,
        input  acc_resp_valid_i, acc_resp_id_i, acc_resp_result_i, acc_resp_error_i
    );

    modport master (
        output req_valid_i, req_insn_i, req_rs1_i, req_rs2_i, req_id_i,
        input  req_ready_o,
        input  resp_valid_o, resp_id_o, resp_result_o, resp_error_o,
        input  acc_req_valid_o, acc_insn_o, acc_rs1_o, acc_rs2_o, acc_id_o,
        output acc_req_ready_i,
        output acc_resp_valid_i, acc_resp_id_i, acc_resp_result_i, acc_resp_error_i
    );
endinterface

// File: rtl/acc_req_arbiter.sv
// Round-robin sharing of one accelerator port among NrReq dispatchers; 0-cycle request/response paths.
// Grant is locked while valid-not-ready; per-source outstanding limit. ACC_ARB_PERF_EN adds grant counters.
module acc_req_arbiter #(
    parameter int NrReq          = 2,
    parameter int IdW            = 3,
    parameter int DataW          = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    acc_req_arbiter_if.slave       bus,
    output logic                   idle_o,
    output logic                   err_o,
    output logic [NrReq-1:0][15:0] perf_grants_o
);
    localparam int SrcW = $clog2(NrReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [SrcW-1:0]             rr_ptr_q, rr_ptr_d;
    logic                        lock_q;
    logic [SrcW-1:0]             lock_src_q;
    logic [NrReq-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic                        err_q;

    logic [NrReq-1:0] elig;
    logic [NrReq-1:0] inc;
    logic [NrReq-1:0] resp_vld;
    logic [SrcW-1:0]  gnt;
    logic             gnt_vld;
    logic             hs;
    logic [SrcW-1:0]  resp_src;
    logic             resp_in_range;

    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            elig[i] = bus.req_valid_i[i] && (cnt_q[i] < CntMax);
        end
    end

    // A locked grant wins outright; otherwise scan from rr_ptr with wrap.
    always_comb begin
        int idx;
        logic [SrcW-1:0] cand;
        idx     = 0;
        cand    = '0;
        gnt     = lock_src_q;
        gnt_vld = lock_q;
        if (!lock_q) begin
            for (int k = 0; k < NrReq; k++) begin
                idx  = (int'(rr_ptr_q) + k) % NrReq;
                cand = SrcW'(idx);
                if (!gnt_vld && elig[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign hs       = gnt_vld && bus.acc_req_ready_i;
    assign rr_ptr_d = (int'(gnt) == NrReq - 1) ? '0 : gnt + SrcW'(1);

    assign bus.acc_req_valid_o = gnt_vld;
    assign bus.acc_insn_o      = bus.req_insn_i[gnt];
    assign bus.acc_rs1_o       = bus.req_rs1_i[gnt];
    assign bus.acc_rs2_o       = bus.req_rs2_i[gnt];
    assign bus.acc_id_o        = {gnt, bus.req_id_i[gnt]};

    assign resp_src      = bus.acc_resp_id_i[SrcW+IdW-1 -: SrcW];
    assign resp_in_range = int'(resp_src) < NrReq;

    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            inc[i]              = hs && (gnt == SrcW'(i));
            bus.req_ready_o[i]  = inc[i];
            resp_vld[i]         = bus.acc_resp_valid_i && resp_in_range && (resp_src == SrcW'(i));
        end
    end

    assign bus.resp_valid_o  = resp_vld;
    assign bus.resp_id_o     = bus.acc_resp_id_i[IdW-1:0];
    assign bus.resp_result_o = bus.acc_resp_result_i;
    assign bus.resp_error_o  = bus.acc_resp_error_i;

    // Issue and retire on the same source in one cycle cancel; never wrap below zero.
    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !resp_vld[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (resp_vld[i] && !inc[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr_q <= rr_ptr_d;
                lock_q   <= 1'b0;
            end else if (gnt_vld) begin
                lock_q     <= 1'b1;
                lock_src_q <= gnt;
            end
            cnt_q <= cnt_d;
            if (bus.acc_resp_valid_i && !resp_in_range) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o  = err_q;
    assign idle_o = !(|bus.req_valid_i) && (cnt_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (lock_q) begin
                assert (bus.req_valid_i[lock_src_q])
                    else $error("acc_req_arbiter: locked requester dropped valid before ready");
            end
            for (int i = 0; i < NrReq; i++) begin
                assert (!(resp_vld[i] && (cnt_q[i] == '0) && !inc[i]))
                    else $error("acc_req_arbiter: response for source %0d with nothing outstanding", i);
            end
        end
    end

`ifdef ACC_ARB_PERF_EN
    logic [NrReq-1:0][15:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (inc[i] && (perf_q[i] != 16'hFFFF)) begin
                    perf_q[i] <= perf_q[i] + 16'd1;
                end
            end
        end
    end

    assign perf_grants_o = perf_q;
`else
    assign perf_grants_o = '0;
`endif

endmodule
